// File: rtl/clocks_monitor.sv
`default_nettype none
//==============================================================================
// Module      : clocks_monitor
// Description : Health monitor for the NeoGeo clock-enable streams. Keeps its
//               own 3-bit divider and 68K phase reference, compares every
//               incoming enable against it and reports lock, sticky error
//               flags and a saturating error-cycle count.
// Revision    : 1.0 - initial release
//==============================================================================
module clocks_monitor #(
    parameter int MIN_PERIOD  = 2,
    parameter int MAX_PERIOD  = 8,
    parameter int LOCK_ROUNDS = 4
) (
    input  logic       CLK,
    input  logic       nRESETP,
    input  logic       CLK_EN_24M_P,
    input  logic       CLK_EN_24M_N,
    input  logic       CLK_EN_12M,
    input  logic       CLK_EN_6MB,
    input  logic       CLK_EN_1HB,
    input  logic       CLK_EN_68K_P,
    input  logic       CLK_EN_68K_N,
    input  logic       CLR_ERR,
    output logic       LOCKED,
    output logic [5:0] ERR_FLAGS,
    output logic [7:0] ERR_COUNT,
    output logic [2:0] PHASE
);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        TRACK  = 1'b1
    } state_t;

    localparam logic [8:0] c_min_period   = 9'(MIN_PERIOD);
    localparam logic [8:0] c_max_period   = 9'(MAX_PERIOD);
    localparam logic [7:0] c_pcnt_timeout = 8'(MAX_PERIOD - 1);
    localparam logic [7:0] c_lock_rounds  = 8'(LOCK_ROUNDS);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_locked;
    logic [5:0] r_err_flags;
    logic [7:0] r_err_count;
    logic [2:0] r_phase;
    logic       r_sync;          // 68K phase has been learned since entering TRACK
    logic       r_exp_p;         // next 24M_P should carry 68K_P (else 68K_N)
    logic [7:0] r_pcnt;
    logic       r_pcnt_valid;
    logic [7:0] r_clean;

    logic       w_track;
    logic       w_enter;
    logic       w_wrap;
    logic       w_stray;
    logic       w_mis_12m;
    logic       w_mis_6mb;
    logic       w_mis_1hb;
    logic       w_68k_ok;
    logic       w_mis_68k;
    logic [8:0] w_period;
    logic       w_bad_period;
    logic       w_timeout;
    logic [5:0] w_err_bits;
    logic       w_err;

    assign w_track = (r_state == TRACK);
    assign w_enter = (r_state == SEARCH) & CLK_EN_24M_N & CLK_EN_1HB;
    assign w_wrap  = w_track & CLK_EN_24M_N & (r_phase == 3'd7);

    // Enables that can only legally appear alongside their parent 24M edge
    assign w_stray = ((CLK_EN_12M | CLK_EN_6MB | CLK_EN_1HB) & ~CLK_EN_24M_N)
                   | (CLK_EN_24M_P & CLK_EN_24M_N)
                   | ((CLK_EN_68K_P | CLK_EN_68K_N) & ~CLK_EN_24M_P);

    assign w_mis_12m = w_track & CLK_EN_24M_N & (CLK_EN_12M != ~r_phase[0]);
    assign w_mis_6mb = w_track & CLK_EN_24M_N & (CLK_EN_6MB != (r_phase == 3'd3));
    assign w_mis_1hb = w_track & CLK_EN_24M_N & (CLK_EN_1HB != (r_phase == 3'd0));

    // Before sync any single 68K edge is accepted; afterwards they must alternate
    assign w_68k_ok  = r_sync ? (r_exp_p ? (CLK_EN_68K_P & ~CLK_EN_68K_N)
                                         : (CLK_EN_68K_N & ~CLK_EN_68K_P))
                              : (CLK_EN_68K_P ^ CLK_EN_68K_N);
    assign w_mis_68k = w_track & CLK_EN_24M_P & ~w_68k_ok;

    assign w_period     = {1'b0, r_pcnt} + 9'd1;
    assign w_bad_period = w_track & CLK_EN_24M_N & r_pcnt_valid
                        & ((w_period < c_min_period) | (w_period > c_max_period));
    assign w_timeout    = w_track & ~CLK_EN_24M_N & r_pcnt_valid & (r_pcnt == c_pcnt_timeout);

    assign w_err_bits = {w_stray, (w_bad_period | w_timeout), w_mis_68k,
                         w_mis_1hb, w_mis_6mb, w_mis_12m};
    assign w_err      = |w_err_bits;

    // State register
    always_ff @(posedge CLK) begin
        if (!nRESETP) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: acquire on the 1HB edge, drop back on any error while tracking
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEARCH:  if (w_enter) w_state_next = TRACK;
            TRACK:   if (w_err)   w_state_next = SEARCH;
            default: w_state_next = SEARCH;
        endcase
    end

    // Error reporting: sticky flags and saturating count, CLR_ERR keeps only new bits
    always_ff @(posedge CLK) begin
        if (!nRESETP) begin
            r_err_flags <= 6'd0;
            r_err_count <= 8'd0;
        end else if (CLR_ERR) begin
            r_err_flags <= w_err_bits;
            r_err_count <= w_err ? 8'd1 : 8'd0;
        end else begin
            r_err_flags <= r_err_flags | w_err_bits;
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Reference divider and 68K phase expectation
    always_ff @(posedge CLK) begin
        if (!nRESETP) begin
            r_phase <= 3'd0;
            r_sync  <= 1'b0;
            r_exp_p <= 1'b0;
        end else begin
            if (w_enter) begin
                r_phase <= 3'd1;
            end else if (w_track && CLK_EN_24M_N) begin
                r_phase <= r_phase + 3'd1;
            end

            if (w_enter) begin
                r_sync <= 1'b0;
            end else if (w_track && CLK_EN_24M_P) begin
                if (!r_sync) begin
                    if (CLK_EN_68K_P ^ CLK_EN_68K_N) begin
                        r_sync  <= 1'b1;
                        r_exp_p <= CLK_EN_68K_N;
                    end
                end else begin
                    r_exp_p <= ~r_exp_p;
                end
            end
        end
    end

    // 24M_N period counter; only meaningful while tracking without errors
    always_ff @(posedge CLK) begin
        if (!nRESETP) begin
            r_pcnt       <= 8'd0;
            r_pcnt_valid <= 1'b0;
        end else if (w_track && !w_err) begin
            if (CLK_EN_24M_N) begin
                r_pcnt       <= 8'd0;
                r_pcnt_valid <= 1'b1;
            end else if (r_pcnt != 8'hFF) begin
                r_pcnt <= r_pcnt + 8'd1;
            end
        end else begin
            r_pcnt       <= 8'd0;
            r_pcnt_valid <= 1'b0;
        end
    end

    // Clean-round counting and lock indication
    always_ff @(posedge CLK) begin
        if (!nRESETP) begin
            r_clean  <= 8'd0;
            r_locked <= 1'b0;
        end else if (w_track && w_err) begin
            r_clean  <= 8'd0;
            r_locked <= 1'b0;
        end else begin
            if (w_wrap && (r_clean != 8'hFF)) begin
                r_clean <= r_clean + 8'd1;
            end
            if (r_clean >= c_lock_rounds) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign LOCKED    = r_locked;
    assign ERR_FLAGS = r_err_flags;
    assign ERR_COUNT = r_err_count;
    assign PHASE     = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_clocks_monitor.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_clocks_monitor
// Description : Self-checking bench for clocks_monitor. An ideal clock-enable
//               generator drives the DUT, directed faults are injected per
//               scenario, and a behavioural model predicts every output.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_clocks_monitor;

    localparam int MIN_P  = 2;
    localparam int MAX_P  = 8;
    localparam int LOCK_R = 4;

    logic CLK = 1'b0;
    logic nRESETP = 1'b0;
    logic p24 = 1'b0, n24 = 1'b0, e12 = 1'b0, e6 = 1'b0, e1h = 1'b0;
    logic k68p = 1'b0, k68n = 1'b0, clr = 1'b0;
    logic       LOCKED;
    logic [5:0] ERR_FLAGS;
    logic [7:0] ERR_COUNT;
    logic [2:0] PHASE;
    logic [17:0] obs;

    int n_cmp  = 0;
    int n_fail = 0;

    // generator state: slot within the 4-CLK 24M period, divider+1, next 68K edge
    int tph = 0;
    int g   = 5;
    bit kp  = 1'b1;

    // behavioural model of the monitor
    bit         m_track  = 1'b0;
    bit         m_locked = 1'b0;
    int         m_phase  = 0;
    int         m_pcnt   = -1;   // -1: no valid period measurement
    int         m_k68    = -1;   // -1: unsynced, 0: expect 68K_P, 1: expect 68K_N
    int         m_rounds = 0;
    int         m_count  = 0;
    logic [5:0] m_flags  = 6'd0;

    clocks_monitor #(
        .MIN_PERIOD (MIN_P),
        .MAX_PERIOD (MAX_P),
        .LOCK_ROUNDS(LOCK_R)
    ) dut (
        .CLK         (CLK),
        .nRESETP     (nRESETP),
        .CLK_EN_24M_P(p24),
        .CLK_EN_24M_N(n24),
        .CLK_EN_12M  (e12),
        .CLK_EN_6MB  (e6),
        .CLK_EN_1HB  (e1h),
        .CLK_EN_68K_P(k68p),
        .CLK_EN_68K_N(k68n),
        .CLR_ERR     (clr),
        .LOCKED      (LOCKED),
        .ERR_FLAGS   (ERR_FLAGS),
        .ERR_COUNT   (ERR_COUNT),
        .PHASE       (PHASE)
    );

    assign obs = {LOCKED, ERR_FLAGS, ERR_COUNT, PHASE};

    always #5 CLK = ~CLK;

    function automatic logic [17:0] mexp();
        return {m_locked, m_flags, 8'(m_count), 3'(m_phase)};
    endfunction

    // Advance the model by one CLK using the inputs present at the edge
    task automatic model_update();
        logic [5:0] nb;
        if (!nRESETP) begin
            m_track = 0; m_locked = 0; m_phase = 0; m_pcnt = -1;
            m_k68 = -1; m_rounds = 0; m_count = 0; m_flags = 6'd0;
            return;
        end
        nb = 6'd0;
        if (((e12 || e6 || e1h) && !n24) || (p24 && n24) || ((k68p || k68n) && !p24))
            nb[5] = 1'b1;
        if (m_track) begin
            if (n24) begin
                nb[0] = (e12 != (m_phase % 2 == 0));
                nb[1] = (e6  != (m_phase == 3));
                nb[2] = (e1h != (m_phase == 0));
                if (m_pcnt >= 0 && (m_pcnt + 1 < MIN_P || m_pcnt + 1 > MAX_P)) nb[4] = 1'b1;
            end else if (m_pcnt >= 0 && m_pcnt + 1 == MAX_P) begin
                nb[4] = 1'b1;
            end
            if (p24) begin
                if (m_k68 < 0) nb[3] = (k68p == k68n);
                else nb[3] = !((m_k68 == 0) ? (k68p && !k68n) : (k68n && !k68p));
            end
        end
        if (clr) begin
            m_flags = nb;
            m_count = (nb != 0) ? 1 : 0;
        end else begin
            m_flags = m_flags | nb;
            if (nb != 0 && m_count < 255) m_count++;
        end
        if (m_track) begin
            if (nb != 0) begin
                m_track = 0; m_rounds = 0; m_locked = 0; m_pcnt = -1;
            end else begin
                if (m_rounds >= LOCK_R) m_locked = 1;
                if (n24) begin
                    if (m_phase == 7 && m_rounds < 255) m_rounds++;
                    m_pcnt = 0;
                end else if (m_pcnt >= 0) begin
                    m_pcnt++;
                end
                if (p24) m_k68 = (m_k68 < 0) ? (k68p ? 1 : 0) : 1 - m_k68;
            end
            if (n24) m_phase = (m_phase + 1) % 8;
        end else if (n24 && e1h) begin
            m_track = 1; m_phase = 1; m_k68 = -1; m_pcnt = -1;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    // Ideal clock generator: 24M_N in slot 0, 24M_P in slot 2, 68K alternating
    task automatic gen(input bit mute_n);
        {n24, p24, e12, e6, e1h, k68p, k68n, clr} = 8'd0;
        if (tph == 0 && !mute_n) begin
            n24 = 1; e12 = (g % 2 == 0); e6 = (g == 3); e1h = (g == 0);
            g = (g + 1) % 8;
        end
        if (tph == 2) begin
            p24 = 1; k68p = kp; k68n = !kp; kp = !kp;
        end
        tph = (tph + 1) % 4;
    endtask

    task automatic test_reset();
        nRESETP = 0;
        for (int i = 0; i < 3; i++) begin
            {n24, p24, e12, e6, e1h, k68p, k68n, clr} = 8'($urandom);
            step();
        end
        n_cmp++;
        if (obs !== 18'd0) begin
            n_fail++; $display("FAIL reset_outputs got %h want 0", obs);
        end
        n_cmp++;
        if (obs !== mexp()) begin
            n_fail++; $display("FAIL reset_model got %h want %h", obs, mexp());
        end
        nRESETP = 1;
        tph = 0; g = 5; kp = 1;
        {n24, p24, e12, e6, e1h, k68p, k68n, clr} = 8'd0;
    endtask

    task automatic test_ideal();
        int pulses = 0;
        int lock_at = -1;
        for (int c = 0; c < 45 * 4; c++) begin
            gen(0);
            if (n24) pulses++;
            step();
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL ideal @%0t got %h want %h", $time, obs, mexp());
            end
            if (LOCKED && lock_at < 0) lock_at = pulses;
        end
        n_cmp++;
        if (lock_at < 0 || lock_at > 40) begin
            n_fail++; $display("FAIL ideal_lock pulses-to-lock got %0d want 1..40", lock_at);
        end
        n_cmp++;
        if (ERR_FLAGS !== 6'd0 || ERR_COUNT !== 8'd0) begin
            n_fail++; $display("FAIL ideal_clean got F=%b C=%0d want 0/0", ERR_FLAGS, ERR_COUNT);
        end
        n_cmp++;
        if (PHASE !== 3'(g)) begin
            n_fail++; $display("FAIL ideal_phase got %0d want %0d", PHASE, g);
        end
    endtask

    task automatic test_drop_6mb();
        bit dropped = 0;
        bit relocked = 0;
        int pulses = 0;
        for (int c = 0; c < 64 && !dropped; c++) begin
            gen(0);
            if (e6) begin e6 = 0; dropped = 1; end
            step();
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL drop6 @%0t got %h want %h", $time, obs, mexp());
            end
        end
        n_cmp++;
        if (!dropped || ERR_FLAGS !== 6'b000010 || ERR_COUNT !== 8'd1 || LOCKED !== 1'b0) begin
            n_fail++; $display("FAIL drop6_err got F=%b C=%0d L=%b want 000010/1/0",
                               ERR_FLAGS, ERR_COUNT, LOCKED);
        end
        for (int c = 0; c < 45 * 4 && !relocked; c++) begin
            gen(0);
            if (n24) pulses++;
            step();
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL drop6_relock @%0t got %h want %h", $time, obs, mexp());
            end
            relocked = LOCKED;
        end
        n_cmp++;
        if (!relocked || pulses > 40) begin
            n_fail++; $display("FAIL drop6_relock_time got lock=%b pulses=%0d want 1 within 40", relocked, pulses);
        end
    endtask

    task automatic test_68k_double();
        int nf = 0;
        bit relocked = 0;
        gen(0); clr = 1; step();
        n_cmp++;
        if (ERR_FLAGS !== 6'd0 || ERR_COUNT !== 8'd0 || LOCKED !== 1'b1) begin
            n_fail++; $display("FAIL k68_clr got F=%b C=%0d L=%b want 0/0/1", ERR_FLAGS, ERR_COUNT, LOCKED);
        end
        for (int c = 0; c < 16; c++) begin
            gen(0);
            if (p24 && nf < 2) begin k68p = 1; k68n = 0; nf++; end
            step();
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL k68 @%0t got %h want %h", $time, obs, mexp());
            end
        end
        n_cmp++;
        if (ERR_FLAGS !== 6'b001000 || ERR_COUNT !== 8'd1 || LOCKED !== 1'b0) begin
            n_fail++; $display("FAIL k68_err got F=%b C=%0d L=%b want 001000/1/0", ERR_FLAGS, ERR_COUNT, LOCKED);
        end
        for (int c = 0; c < 45 * 4 && !relocked; c++) begin
            gen(0); step();
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL k68_relock @%0t got %h want %h", $time, obs, mexp());
            end
            relocked = LOCKED;
        end
        n_cmp++;
        if (!relocked) begin
            n_fail++; $display("FAIL k68_relock_time got lock=0 want 1");
        end
    endtask

    task automatic test_period();
        bit relocked = 0;
        bit done = 0;
        gen(0); clr = 1; step();
        for (int c = 0; c < 12; c++) begin
            gen(1); step();
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL timeout @%0t got %h want %h", $time, obs, mexp());
            end
        end
        n_cmp++;
        if (ERR_FLAGS !== 6'b010000 || ERR_COUNT !== 8'd1 || LOCKED !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err got F=%b C=%0d L=%b want 010000/1/0", ERR_FLAGS, ERR_COUNT, LOCKED);
        end
        for (int c = 0; c < 12; c++) begin
            gen(0); step();
        end
        n_cmp++;
        if (ERR_FLAGS !== 6'b010000 || ERR_COUNT !== 8'd1) begin
            n_fail++; $display("FAIL timeout_once got F=%b C=%0d want 010000/1", ERR_FLAGS, ERR_COUNT);
        end
        for (int c = 0; c < 45 * 4 && !relocked; c++) begin
            gen(0); step();
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL period_relock @%0t got %h want %h", $time, obs, mexp());
            end
            relocked = LOCKED;
        end
        n_cmp++;
        if (!relocked) begin
            n_fail++; $display("FAIL period_relock_time got lock=0 want 1");
        end
        gen(0); clr = 1; step();
        for (int c = 0; c < 8 && !done; c++) begin
            if (tph == 1) begin
                gen(0);
                n24 = 1; e12 = (g % 2 == 0); e6 = (g == 3); e1h = (g == 0);
                g = (g + 1) % 8;
                done = 1;
            end else begin
                gen(0);
            end
            step();
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL short_period @%0t got %h want %h", $time, obs, mexp());
            end
        end
        n_cmp++;
        if (!done || ERR_FLAGS !== 6'b010000 || ERR_COUNT !== 8'd1 || LOCKED !== 1'b0) begin
            n_fail++; $display("FAIL short_period_err got F=%b C=%0d L=%b want 010000/1/0", ERR_FLAGS, ERR_COUNT, LOCKED);
        end
    endtask

    task automatic test_stray_and_clear();
        int guard = 0;
        gen(0); clr = 1; step();
        gen(0); n24 = 1; p24 = 1; step();
        n_cmp++;
        if (ERR_FLAGS !== 6'b100000 || ERR_COUNT !== 8'd1 || LOCKED !== 1'b0) begin
            n_fail++; $display("FAIL stray_pn got F=%b C=%0d L=%b want 100000/1/0", ERR_FLAGS, ERR_COUNT, LOCKED);
        end
        while (!(m_track && tph == 0) && guard < 200) begin
            gen(0); step(); guard++;
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL stray_track @%0t got %h want %h", $time, obs, mexp());
            end
        end
        gen(0); e12 = ~e12; clr = 1; step();
        n_cmp++;
        if (guard >= 200 || ERR_FLAGS !== 6'b000001 || ERR_COUNT !== 8'd1) begin
            n_fail++; $display("FAIL clr_with_err got F=%b C=%0d want 000001/1", ERR_FLAGS, ERR_COUNT);
        end
    endtask

    task automatic test_saturate_reset();
        for (int c = 0; c < 300; c++) begin
            {n24, p24, e12, e6, e1h, k68p, k68n, clr} = 8'd0;
            e12 = 1;
            step();
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL saturate @%0t got %h want %h", $time, obs, mexp());
            end
        end
        n_cmp++;
        if (ERR_COUNT !== 8'd255 || ERR_FLAGS[5] !== 1'b1) begin
            n_fail++; $display("FAIL saturate_hold got C=%0d F=%b want 255/1xxxxx", ERR_COUNT, ERR_FLAGS);
        end
        nRESETP = 0;
        {n24, p24, e12, e6, e1h, k68p, k68n, clr} = 8'($urandom);
        step();
        nRESETP = 1;
        {n24, p24, e12, e6, e1h, k68p, k68n, clr} = 8'd0;
        n_cmp++;
        if (obs !== 18'd0) begin
            n_fail++; $display("FAIL post_reset got %h want 0", obs);
        end
    endtask

    task automatic test_random();
        tph = 0; g = $urandom_range(0, 7); kp = 1'($urandom_range(0, 1));
        for (int c = 0; c < 3000; c++) begin
            gen($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) begin
                case ($urandom_range(0, 6))
                    0: n24  = ~n24;
                    1: p24  = ~p24;
                    2: e12  = ~e12;
                    3: e6   = ~e6;
                    4: e1h  = ~e1h;
                    5: k68p = ~k68p;
                    default: k68n = ~k68n;
                endcase
            end
            if ($urandom_range(0, 99) == 0) clr = 1;
            nRESETP = ($urandom_range(0, 999) != 0);
            step();
            n_cmp++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL random @%0t got %h want %h", $time, obs, mexp());
            end
        end
        nRESETP = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ideal();
        test_drop_6mb();
        test_68k_double();
        test_period();
        test_stray_and_clear();
        test_saturate_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
